// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding,
// PC-select encodings, opcode constants and next-PC class encoding.
package ctrl_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_PC_INC = 3'd3,
        ST_PC_BR  = 3'd4,
        ST_PC_JMP = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // PC select encodings
    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    // Opcodes with sequencing significance (opcode[3]=0 are plain ALU ops)
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;
    localparam logic [3:0] OP_LI  = 4'b1010;
    localparam logic [3:0] OP_BZ  = 4'b1011;
    localparam logic [3:0] OP_BNZ = 4'b1100;
    localparam logic [3:0] OP_BR1 = 4'b1101;
    localparam logic [3:0] OP_BR2 = 4'b1110;
    localparam logic [3:0] OP_SYS = 4'b1111;

    // What happens to the PC after an instruction completes
    typedef enum logic [1:0] {
        CLS_INC  = 2'd0,
        CLS_BR   = 2'd1,
        CLS_JMP  = 2'd2,
        CLS_HALT = 2'd3
    } pc_class_t;

    // Loads and stores are the only instructions that touch memory in EXEC
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_next_pc_class.sv
// Combinational classifier: decides how the PC moves after the current
// instruction, whether the instruction is a memory access, and whether the
// SYS opcode carries an unsupported DA qualifier.
module ctrl_next_pc_class
    import ctrl_pkg::*;
#(
    parameter int DA_W = 4
) (
    input  logic [3:0]      opcode_i,
    input  logic [DA_W-1:0] da_i,
    input  logic            zero_flag_i,
    output logic [1:0]      cls_o,
    output logic            illegal_o,
    output logic            is_mem_o
);

    // Opcode/flag decode into a next-PC class
    always_comb begin
        cls_o     = CLS_INC;
        illegal_o = 1'b0;
        is_mem_o  = is_mem_op(opcode_i);
        if (opcode_i[3]) begin
            case (opcode_i)
                OP_BZ:          cls_o = zero_flag_i ? CLS_BR : CLS_INC;
                OP_BNZ:         cls_o = zero_flag_i ? CLS_INC : CLS_BR;
                OP_BR1, OP_BR2: cls_o = CLS_BR;
                OP_SYS: begin
                    if (da_i == '0) begin
                        cls_o = CLS_JMP;
                    end else if (da_i == '1) begin
                        cls_o = CLS_HALT;
                    end else begin
                        // Unknown SYS variant: flag it and carry on sequentially
                        cls_o     = CLS_INC;
                        illegal_o = 1'b1;
                    end
                end
                default:        cls_o = CLS_INC;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: RESET -> FETCH -> EXEC -> PC update -> FETCH,
// with memory wait-state handshaking, a wait timeout into a terminal ERR
// state, a sticky illegal-opcode flag and an optional retired-instruction
// counter enabled by defining MULTICYCLE_CTRL_PERF_CNT_EN.
// Handshake: in FETCH and in EXEC of a load/store, mem_req is held high and
// the access completes in the first cycle mem_ready is sampled high; the
// controller never drops mem_req before that cycle (except on timeout/reset).
// dbg_state exposes the current state for checkers and debug.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DA_W     = 4,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [DA_W-1:0]  DA,
    input  logic             zero_flag,
    input  logic             rw_dec,
    input  logic             mem_ready,
    output logic [1:0]       PS,
    output logic             IL,
    output logic             MM,
    output logic             RW,
    output logic             mem_req,
    output logic             done,
    output logic             err,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [2:0]       dbg_state
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    // Last tolerated wait count: one more low cycle from here is a timeout
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(WAIT_MAX);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;

    logic [1:0]        cls_raw;
    pc_class_t         cls;
    logic              cls_illegal;
    logic              is_mem;
    logic              exec_done;

    ctrl_next_pc_class #(
        .DA_W (DA_W)
    ) u_class (
        .opcode_i    (opcode),
        .da_i        (DA),
        .zero_flag_i (zero_flag),
        .cls_o       (cls_raw),
        .illegal_o   (cls_illegal),
        .is_mem_o    (is_mem)
    );

    assign cls = pc_class_t'(cls_raw);

    // EXEC finishes when a non-memory op is seen or memory signals ready
    assign exec_done = (state_q == ST_EXEC) && (!is_mem || mem_ready);

    // Next-state, wait-counter and illegal-flag logic
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WAIT_W'(1);
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    illegal_d = illegal_q | cls_illegal;
                    case (cls)
                        CLS_BR:   state_d = ST_PC_BR;
                        CLS_JMP:  state_d = ST_PC_JMP;
                        CLS_HALT: state_d = ST_HALT;
                        default:  state_d = ST_PC_INC;
                    endcase
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WAIT_W'(1);
                end
            end
            ST_PC_INC, ST_PC_BR, ST_PC_JMP: state_d = ST_FETCH;
            default: state_d = state_q;  // HALT and ERR are terminal
        endcase
    end

    // State register with asynchronous abort on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RESET;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath control outputs decoded from state and current inputs
    always_comb begin
        PS      = PS_HOLD;
        IL      = 1'b0;
        MM      = 1'b1;
        RW      = 1'b0;
        mem_req = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                IL      = mem_ready;
            end
            ST_EXEC: begin
                MM      = 1'b0;
                mem_req = is_mem;
                RW      = rw_dec & exec_done;
            end
            ST_PC_INC: PS = PS_INC;
            ST_PC_BR:  PS = PS_BR;
            ST_PC_JMP: PS = PS_JMP;
            ST_HALT:   done = 1'b1;
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal   = illegal_q;
    assign dbg_state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Retired-instruction counter; no completions happen in HALT/ERR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (exec_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule
